mips_run_ctrl: RTL and testbench

Synthesizable run controller for the single-cycle MIPS core: sequences a core reset, then gates the core clock enable until a halt condition. Halt conditions are a PC breakpoint match, an exhausted cycle budget, or an external halt request. Generalises the fixed "tick until PC == 0x20" loop with parametrised breakpoint count, a cycle budget, and single-step mode. Sits between the board/bench control inputs and mips_top's reset and clock-enable.

---
 rtl/mips_run_ctrl.sv | 144 ++++++++++++++
 tb/tb_mips_run_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_ctrl.sv
// Run controller for the single-cycle MIPS core: resets the core, then
// enables it until a breakpoint, cycle budget or halt request stops it.
// Optional single-step mode advances the core one cycle per step pulse.
module mips_run_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int N_BKPT     = 4,
  parameter int CYC_W      = 32,
  parameter int RST_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic                     step,
  input  logic                     halt_req,
  input  logic [N_BKPT-1:0]        bkpt_en,
  input  logic [N_BKPT*ADDR_W-1:0] bkpt_addr,
  input  logic [CYC_W-1:0]         cycle_budget,
  input  logic [ADDR_W-1:0]        pc_current,
  output logic                     cpu_rst,
  output logic                     cpu_ce,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               done_cause,
  output logic [2:0]               hit_idx,
  output logic [CYC_W-1:0]         cycle_count
);

  localparam int RCW = $clog2(RST_CYCLES + 1);
  localparam logic [RCW-1:0] RST_LOAD = RCW'(RST_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CORE_RST  = 3'd1,
    S_RUN       = 3'd2,
    S_STEP_WAIT = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [RCW-1:0]   rcnt_q, rcnt_d;
  logic [CYC_W-1:0] count_q, count_d;
  logic [1:0]       cause_q, cause_d;
  logic [2:0]       idx_q, idx_d;
  logic             cpu_rst_q, busy_q, done_q;
  logic             ce_now;

  logic             bkpt_hit;
  logic [2:0]       bkpt_idx;
  logic             budget_hit;
  logic             hit;
  logic [1:0]       hit_cause;
  logic [CYC_W-1:0] count_inc;

  // Breakpoint compare; scanning downward leaves the lowest matching index.
  always_comb begin
    bkpt_hit = 1'b0;
    bkpt_idx = 3'd0;
    for (int i = N_BKPT - 1; i >= 0; i--) begin
      if (bkpt_en[i] && (pc_current == bkpt_addr[i*ADDR_W +: ADDR_W])) begin
        bkpt_hit = 1'b1;
        bkpt_idx = 3'(i);
      end
    end
  end

  assign budget_hit = (cycle_budget != '0) && (count_q == cycle_budget);
  assign hit        = bkpt_hit || budget_hit || halt_req;
  assign hit_cause  = bkpt_hit ? 2'd1 : (budget_hit ? 2'd2 : 2'd3);
  assign count_inc  = (&count_q) ? count_q : count_q + CYC_W'(1);

  // Next-state and core enable. The enable is decided from the PC of the
  // same cycle so the instruction sitting at a halt point never executes.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    count_d = count_q;
    cause_d = cause_q;
    idx_d   = idx_q;
    ce_now  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_CORE_RST;
          rcnt_d  = RST_LOAD;
          count_d = '0;
          cause_d = 2'd0;
          idx_d   = 3'd0;
        end
      end
      S_CORE_RST: begin
        if (rcnt_q <= RCW'(1)) begin
          state_d = (mode == 2'd1) ? S_STEP_WAIT : S_RUN;
        end else begin
          rcnt_d = rcnt_q - RCW'(1);
        end
      end
      S_RUN, S_STEP_WAIT: begin
        if (hit) begin
          state_d = S_DONE;
          cause_d = hit_cause;
          idx_d   = bkpt_hit ? bkpt_idx : 3'd0;
        end else if ((state_q == S_RUN) || step) begin
          ce_now  = 1'b1;
          count_d = count_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered status outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rcnt_q    <= '0;
      count_q   <= '0;
      cause_q   <= 2'd0;
      idx_q     <= 3'd0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      count_q   <= count_d;
      cause_q   <= cause_d;
      idx_q     <= idx_d;
      cpu_rst_q <= (state_d == S_IDLE) || (state_d == S_CORE_RST);
      busy_q    <= (state_d == S_CORE_RST) || (state_d == S_RUN) ||
                   (state_d == S_STEP_WAIT);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign cpu_rst     = cpu_rst_q;
  assign cpu_ce      = ce_now;
  assign busy        = busy_q;
  assign done        = done_q;
  assign done_cause  = cause_q;
  assign hit_idx     = idx_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: a linear-PC core model plus a per-run reference
// that finds the first halting cycle by scanning the run cycle by cycle.
module tb_mips_run_ctrl;
  localparam int ADDR_W     = 32;
  localparam int N_BKPT     = 4;
  localparam int CYC_W      = 32;
  localparam int RST_CYCLES = 2;
  localparam int NO_HALT    = 100000;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     start = 1'b0;
  logic [1:0]               mode = 2'd0;
  logic                     step = 1'b0;
  logic                     halt_req = 1'b0;
  logic [N_BKPT-1:0]        bkpt_en = '0;
  logic [N_BKPT*ADDR_W-1:0] bkpt_addr = '0;
  logic [CYC_W-1:0]         cycle_budget = '0;
  logic [ADDR_W-1:0]        pc_model = '0;
  logic                     cpu_rst, cpu_ce, busy, done;
  logic [1:0]               done_cause;
  logic [2:0]               hit_idx;
  logic [CYC_W-1:0]         cycle_count;

  int total = 0;
  int bad = 0;
  int ce_total = 0;
  int rst_total = 0;

  mips_run_ctrl #(
    .ADDR_W(ADDR_W), .N_BKPT(N_BKPT), .CYC_W(CYC_W), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .step(step),
    .halt_req(halt_req), .bkpt_en(bkpt_en), .bkpt_addr(bkpt_addr),
    .cycle_budget(cycle_budget), .pc_current(pc_model),
    .cpu_rst(cpu_rst), .cpu_ce(cpu_ce), .busy(busy), .done(done),
    .done_cause(done_cause), .hit_idx(hit_idx), .cycle_count(cycle_count)
  );

  initial forever #5 clk = ~clk;

  // Straight-line core: PC steps by 4 per enabled cycle, 0 while in reset.
  always @(posedge clk) begin
    if (cpu_rst) pc_model <= '0;
    else if (cpu_ce) pc_model <= pc_model + 32'd4;
  end

  // Running tallies of enabled core cycles and core-reset cycles.
  always @(posedge clk) begin
    if (cpu_ce) ce_total++;
    if (busy && cpu_rst) rst_total++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: the core executes PC 4*n on run cycle n; the run stops at
  // the first n with any halt condition, cause chosen by priority.
  task automatic model(input logic [N_BKPT-1:0] en, input logic [N_BKPT*ADDR_W-1:0] a,
                       input logic [CYC_W-1:0] budget, input int h,
                       output int n, output int cause, output int idx);
    n = 0; cause = 0; idx = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = N_BKPT - 1; i >= 0; i--)
        if (en[i] && a[i*ADDR_W +: ADDR_W] == ADDR_W'(4 * c)) begin
          cause = 1; idx = i;
        end
      if (cause == 0 && budget != 0 && budget == CYC_W'(c)) cause = 2;
      if (cause == 0 && c >= h) cause = 3;
      if (cause != 0) begin
        n = c;
        return;
      end
    end
  endtask

  task automatic run_case(input string tag, input logic [N_BKPT-1:0] en,
                          input logic [N_BKPT*ADDR_W-1:0] a, input logic [CYC_W-1:0] budget,
                          input int h, input logic [1:0] md, input bit poke);
    int ce0, rs0, n, cause, idx;
    bit ok;
    @(negedge clk);
    bkpt_en = en; bkpt_addr = a; cycle_budget = budget; mode = md;
    halt_req = 1'b0; ce0 = ce_total; rs0 = rst_total; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " cleared count"}, 64'(cycle_count), 64'd0);
    chk({tag, " done low"}, 64'(done), 64'd0);
    ok = 1'b0;
    for (int t = 0; t < 600; t++) begin
      halt_req = (pc_model == ADDR_W'(4 * h));
      if (done) begin
        ok = 1'b1;
        break;
      end
      start = (poke && t == RST_CYCLES + 3);
      @(negedge clk);
    end
    halt_req = 1'b0; start = 1'b0;
    chk({tag, " finished"}, 64'(ok), 64'd1);
    model(en, a, budget, h, n, cause, idx);
    chk({tag, " cause"}, 64'(done_cause), 64'(cause));
    chk({tag, " count"}, 64'(cycle_count), 64'(n));
    chk({tag, " ce pulses"}, 64'(ce_total - ce0), 64'(n));
    chk({tag, " pc"}, 64'(pc_model), 64'(4 * n));
    chk({tag, " rst cycles"}, 64'(rst_total - rs0), 64'(RST_CYCLES));
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " cpu_rst"}, 64'(cpu_rst), 64'd0);
    if (cause == 1) chk({tag, " hit_idx"}, 64'(hit_idx), 64'(idx));
  endtask

  initial begin
    logic [N_BKPT*ADDR_W-1:0] a;
    int ce0;
    bit ok;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst cpu_rst", 64'(cpu_rst), 64'd1);
    chk("rst cpu_ce", 64'(cpu_ce), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst cause", 64'(done_cause), 64'd0);
    chk("rst hit_idx", 64'(hit_idx), 64'd0);
    chk("rst count", 64'(cycle_count), 64'd0);
    rst = 1'b1;

    // Directed runs
    a = '0; a[0*ADDR_W +: ADDR_W] = 32'h20;
    run_case("bkpt20", 4'b0001, a, '0, NO_HALT, 2'd0, 1'b0);
    run_case("budget5", 4'b0000, '0, 32'd5, NO_HALT, 2'd0, 1'b1);
    run_case("budget5 rerun", 4'b0000, '0, 32'd5, NO_HALT, 2'd0, 1'b0);
    a = '0; a[1*ADDR_W +: ADDR_W] = 32'h10; a[2*ADDR_W +: ADDR_W] = 32'h10;
    run_case("dual bkpt+halt", 4'b0110, a, '0, 4, 2'd0, 1'b0);
    run_case("bkpt at 0", 4'b0001, '0, '0, NO_HALT, 2'd0, 1'b0);

    // Single-step mode
    @(negedge clk);
    bkpt_en = '0; cycle_budget = '0; mode = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    ce0 = ce_total;
    for (int s = 0; s < 3; s++) begin
      step = 1'b1; @(negedge clk);
      step = 1'b0; repeat (3) @(negedge clk);
    end
    chk("step pc", 64'(pc_model), 64'h0c);
    chk("step pulses", 64'(ce_total - ce0), 64'd3);
    chk("step count", 64'(cycle_count), 64'd3);
    chk("step busy", 64'(busy), 64'd1);
    chk("step done", 64'(done), 64'd0);
    step = 1'b1; repeat (4) @(negedge clk);
    step = 1'b0;
    chk("step held count", 64'(cycle_count), 64'd7);
    halt_req = 1'b1; @(negedge clk);
    halt_req = 1'b0;
    chk("step halt done", 64'(done), 64'd1);
    chk("step halt cause", 64'(done_cause), 64'd3);
    ce0 = ce_total;
    step = 1'b1; @(negedge clk);
    step = 1'b0; @(negedge clk);
    chk("done ignores step", 64'(ce_total - ce0), 64'd0);
    chk("done holds count", 64'(cycle_count), 64'd7);
    chk("done holds pc", 64'(pc_model), 64'h1c);
    mode = 2'd0;

    // Reset in the middle of a run
    start = 1'b1; @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (pc_model == 32'h0c) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("midrun reached", 64'(ok), 64'd1);
    chk("midrun count", 64'(cycle_count), 64'd3);
    rst = 1'b0; @(negedge clk);
    chk("midrun rst cpu_rst", 64'(cpu_rst), 64'd1);
    chk("midrun rst cpu_ce", 64'(cpu_ce), 64'd0);
    chk("midrun rst count", 64'(cycle_count), 64'd0);
    chk("midrun rst done", 64'(done), 64'd0);
    chk("midrun rst busy", 64'(busy), 64'd0);
    rst = 1'b1;

    // Randomized runs (mode 0 and the reserved encodings)
    for (int r = 0; r < 25; r++) begin
      logic [N_BKPT-1:0] en;
      logic [CYC_W-1:0]  bud;
      logic [1:0]        md;
      int                h, m;
      en = N_BKPT'($urandom);
      for (int i = 0; i < N_BKPT; i++)
        a[i*ADDR_W +: ADDR_W] = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom)
                                                             : ADDR_W'(4 * $urandom_range(0, 40));
      bud = ($urandom_range(0, 1) == 0) ? '0 : CYC_W'($urandom_range(1, 40));
      h = $urandom_range(0, 50);
      m = $urandom_range(0, 2);
      md = (m == 0) ? 2'd0 : ((m == 1) ? 2'd2 : 2'd3);
      run_case($sformatf("rand%0d", r), en, a, bud, h, md, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
